// File: rtl/audio_ctrl_pkg.sv
// Shared definitions for the audio playback controller: play-state encoding,
// LED codes and default sizing parameters.
package audio_ctrl_pkg;

    localparam int DEF_SAMPLE_W   = 16;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_LOW_WATER  = 4;
    localparam int SCOUNT_W       = 24;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } play_state_e;

    localparam logic [3:0] LED_STOP  = 4'b0001;
    localparam logic [3:0] LED_PLAY  = 4'b0010;
    localparam logic [3:0] LED_PAUSE = 4'b0100;
    localparam logic [3:0] LED_RSVD  = 4'b1000;

    function automatic logic [3:0] state_to_leds(input play_state_e s);
        logic [3:0] leds;
        leds = LED_RSVD;
        case (s)
            ST_STOP:  leds = LED_STOP;
            ST_PLAY:  leds = LED_PLAY;
            ST_PAUSE: leds = LED_PAUSE;
            default:  leds = LED_RSVD;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Sample buffer: power-of-two circular FIFO with occupancy count and flush.
// Writes when full and reads when empty are dropped internally.
module sample_fifo
    import audio_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_SAMPLE_W,
    parameter int DEPTH  = DEF_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_wr, do_rd;

    assign full_o    = (count_q == FULL_LVL);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign do_wr = wr_en_i && !full_o && !flush_i;
    assign do_rd = rd_en_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observable through count.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/audio_play_ctrl.sv
// Audio playback controller: button-driven STOP/PLAY/PAUSE sequencer feeding
// buffered samples to the codec on each DAC frame tick.
//
//  state    | meaning
//  ST_STOP  | idle, buffer flushed, source not requested
//  ST_PLAY  | buffer filling, one sample popped per frame_tick
//  ST_PAUSE | buffer filling, output frozen
module audio_play_ctrl
    import audio_ctrl_pkg::*;
#(
    parameter int SAMPLE_W   = DEF_SAMPLE_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LOW_WATER  = DEF_LOW_WATER
) (
    input  logic                clkin_50,
    input  logic                rst,
    input  logic [3:0]          pb_n_fltrd,
    input  logic [SAMPLE_W-1:0] fill_data,
    input  logic                fill_valid,
    output logic                fill_ready,
    output logic                fill_req,
    input  logic                frame_tick,
    output logic [SAMPLE_W-1:0] dac_sample,
    output logic                dac_load,
    output logic                underrun,
    output logic [3:0]          state_leds,
    output logic [23:0]         sample_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LOW_LVL = CNT_W'(LOW_WATER);

    play_state_e         state_q, state_d;
    logic [1:0]          pb_q;
    logic                play_evt_q, stop_evt_q;
    logic                req_q;
    logic [SAMPLE_W-1:0] dac_sample_q, dac_sample_d;
    logic                dac_load_q, dac_load_d;
    logic                underrun_q, underrun_d;
    logic [23:0]         scount_q, scount_d;

    logic [1:0]          press;
    logic                enter_stop, tick_play, pop, wr_en;
    logic [SAMPLE_W-1:0] head;
    logic [CNT_W-1:0]    count;
    logic                full, empty;
    logic                unused_pb;

    assign unused_pb = ^pb_n_fltrd[3:2];

    // Falling edge of the active-low buttons; a held button fires once.
    assign press = pb_q & ~pb_n_fltrd[1:0];

    always_ff @(posedge clkin_50 or posedge rst) begin
        if (rst) begin
            pb_q       <= 2'b11;
            play_evt_q <= 1'b0;
            stop_evt_q <= 1'b0;
        end else begin
            pb_q       <= pb_n_fltrd[1:0];
            play_evt_q <= press[0];
            stop_evt_q <= press[1];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (play_evt_q && !stop_evt_q) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (stop_evt_q)      state_d = ST_STOP;
                else if (play_evt_q) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (stop_evt_q)      state_d = ST_STOP;
                else if (play_evt_q) state_d = ST_PLAY;
            end
            default: state_d = ST_STOP;
        endcase
    end

    assign enter_stop = (state_d == ST_STOP) && (state_q != ST_STOP);
    assign tick_play  = frame_tick && (state_q == ST_PLAY) && !enter_stop;
    assign pop        = tick_play && !empty;
    assign fill_ready = !full && (state_q != ST_STOP);
    assign wr_en      = fill_valid && fill_ready;

    // Request latches on at the low-water mark and holds until the buffer is full.
    assign fill_req = (state_q != ST_STOP) && !full && ((count <= LOW_LVL) || req_q);

    always_comb begin
        dac_sample_d = dac_sample_q;
        dac_load_d   = 1'b0;
        underrun_d   = underrun_q;
        scount_d     = scount_q;
        if (enter_stop) begin
            dac_sample_d = '0;
            dac_load_d   = 1'b1;
            underrun_d   = 1'b0;
            scount_d     = '0;
        end else if (tick_play) begin
            dac_load_d = 1'b1;
            if (!empty) begin
                dac_sample_d = head;
                if (scount_q != '1) scount_d = scount_q + 1'b1;
            end else begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clkin_50 or posedge rst) begin
        if (rst) begin
            state_q      <= ST_STOP;
            req_q        <= 1'b0;
            dac_sample_q <= '0;
            dac_load_q   <= 1'b0;
            underrun_q   <= 1'b0;
            scount_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= fill_req;
            dac_sample_q <= dac_sample_d;
            dac_load_q   <= dac_load_d;
            underrun_q   <= underrun_d;
            scount_q     <= scount_d;
        end
    end

    sample_fifo #(
        .DATA_W (SAMPLE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clkin_50),
        .rst_i     (rst),
        .flush_i   (enter_stop),
        .wr_en_i   (wr_en),
        .wr_data_i (fill_data),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .count_o   (count),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign dac_sample   = dac_sample_q;
    assign dac_load     = dac_load_q;
    assign underrun     = underrun_q;
    assign sample_count = scount_q;
    assign state_leds   = state_to_leds(state_q);

endmodule

// File: tb/tb_audio_play_ctrl.sv
// Directed self-checking bench for audio_play_ctrl: transport control,
// buffering, underrun, simultaneous events and mid-playback reset.
module tb_audio_play_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  pb_n;
    logic [15:0] fill_data;
    logic        fill_valid;
    logic        fill_ready;
    logic        fill_req;
    logic        frame_tick;
    logic [15:0] dac_sample;
    logic        dac_load;
    logic        underrun;
    logic [3:0]  state_leds;
    logic [23:0] sample_count;

    int n_cmp = 0;
    int n_bad = 0;

    audio_play_ctrl #(.SAMPLE_W(16), .FIFO_DEPTH(16), .LOW_WATER(4)) dut (
        .clkin_50     (clk),
        .rst          (rst),
        .pb_n_fltrd   (pb_n),
        .fill_data    (fill_data),
        .fill_valid   (fill_valid),
        .fill_ready   (fill_ready),
        .fill_req     (fill_req),
        .frame_tick   (frame_tick),
        .dac_sample   (dac_sample),
        .dac_load     (dac_load),
        .underrun     (underrun),
        .state_leds   (state_leds),
        .sample_count (sample_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a button mask low across two rising edges, then release.
    task automatic press(input logic [1:0] m);
        pb_n = {2'b11, ~m};
        @(negedge clk);
        @(negedge clk);
        pb_n = 4'hF;
    endtask

    task automatic push(input logic [15:0] d);
        fill_data  = d;
        fill_valid = 1'b1;
        @(negedge clk);
        fill_valid = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (state_leds !== 4'b0001) begin n_bad++; $display("FAIL rst_leds got %b want 0001", state_leds); end
        n_cmp++; if (fill_ready !== 1'b0) begin n_bad++; $display("FAIL rst_fill_ready got %b want 0", fill_ready); end
        n_cmp++; if (fill_req !== 1'b0) begin n_bad++; $display("FAIL rst_fill_req got %b want 0", fill_req); end
        n_cmp++; if (dac_sample !== 16'h0000) begin n_bad++; $display("FAIL rst_dac_sample got %h want 0000", dac_sample); end
        n_cmp++; if (dac_load !== 1'b0) begin n_bad++; $display("FAIL rst_dac_load got %b want 0", dac_load); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun got %b want 0", underrun); end
        n_cmp++; if (sample_count !== 24'd0) begin n_bad++; $display("FAIL rst_sample_count got %0d want 0", sample_count); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (dac_load !== 1'b0) begin n_bad++; $display("FAIL rst_release_load got %b want 0", dac_load); end
    endtask

    task automatic test_play_press();
        press(2'b01);
        n_cmp++; if (state_leds !== 4'b0010) begin n_bad++; $display("FAIL play_leds got %b want 0010", state_leds); end
        n_cmp++; if (fill_req !== 1'b1) begin n_bad++; $display("FAIL play_fill_req got %b want 1", fill_req); end
        n_cmp++; if (fill_ready !== 1'b1) begin n_bad++; $display("FAIL play_fill_ready got %b want 1", fill_ready); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) push(16'(i));
        n_cmp++; if (fill_ready !== 1'b0) begin n_bad++; $display("FAIL full_fill_ready got %b want 0", fill_ready); end
        n_cmp++; if (fill_req !== 1'b0) begin n_bad++; $display("FAIL full_fill_req got %b want 0", fill_req); end
        for (int i = 1; i <= 16; i++) begin
            tick();
            n_cmp++;
            if (dac_load !== 1'b1 || dac_sample !== 16'(i)) begin
                n_bad++;
                $display("FAIL drain_%0d got load=%b sample=%h want load=1 sample=%h", i, dac_load, dac_sample, 16'(i));
            end
        end
        n_cmp++; if (sample_count !== 24'd16) begin n_bad++; $display("FAIL drain_count got %0d want 16", sample_count); end
        n_cmp++; if (fill_req !== 1'b1) begin n_bad++; $display("FAIL drain_fill_req got %b want 1", fill_req); end
    endtask

    task automatic test_underrun();
        tick();
        n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL underrun_flag got %b want 1", underrun); end
        n_cmp++; if (dac_sample !== 16'h0010) begin n_bad++; $display("FAIL underrun_hold got %h want 0010", dac_sample); end
        n_cmp++; if (dac_load !== 1'b1) begin n_bad++; $display("FAIL underrun_load got %b want 1", dac_load); end
        @(negedge clk);
        n_cmp++; if (dac_load !== 1'b0) begin n_bad++; $display("FAIL underrun_load_once got %b want 0", dac_load); end
        n_cmp++; if (sample_count !== 24'd16) begin n_bad++; $display("FAIL underrun_count got %0d want 16", sample_count); end
        n_cmp++; if (state_leds !== 4'b0010) begin n_bad++; $display("FAIL underrun_state got %b want 0010", state_leds); end
    endtask

    task automatic test_simul_stop();
        push(16'h0021);
        push(16'h0022);
        push(16'h0023);
        press(2'b11);
        n_cmp++; if (state_leds !== 4'b0001) begin n_bad++; $display("FAIL both_leds got %b want 0001", state_leds); end
        n_cmp++; if (dac_sample !== 16'h0000) begin n_bad++; $display("FAIL both_dac_sample got %h want 0000", dac_sample); end
        n_cmp++; if (dac_load !== 1'b1) begin n_bad++; $display("FAIL both_stop_load got %b want 1", dac_load); end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL both_underrun got %b want 0", underrun); end
        n_cmp++; if (sample_count !== 24'd0) begin n_bad++; $display("FAIL both_count got %0d want 0", sample_count); end
        n_cmp++; if (fill_ready !== 1'b0 || fill_req !== 1'b0) begin n_bad++; $display("FAIL both_fill got ready=%b req=%b want 0 0", fill_ready, fill_req); end
        tick();
        n_cmp++; if (dac_load !== 1'b0) begin n_bad++; $display("FAIL stop_tick_load got %b want 0", dac_load); end
        press(2'b01);
        tick();
        n_cmp++; if (underrun !== 1'b1 || dac_sample !== 16'h0000) begin n_bad++; $display("FAIL flushed got underrun=%b sample=%h want 1 0000", underrun, dac_sample); end
    endtask

    task automatic test_held_button();
        pb_n = 4'hE;
        repeat (1000) @(negedge clk);
        n_cmp++; if (state_leds !== 4'b0100) begin n_bad++; $display("FAIL held_leds got %b want 0100", state_leds); end
        pb_n = 4'hF;
        repeat (3) @(negedge clk);
        n_cmp++; if (state_leds !== 4'b0100) begin n_bad++; $display("FAIL held_release got %b want 0100", state_leds); end
        tick();
        n_cmp++; if (dac_load !== 1'b0 || dac_sample !== 16'h0000) begin n_bad++; $display("FAIL pause_tick got load=%b sample=%h want 0 0000", dac_load, dac_sample); end
        press(2'b10);
        n_cmp++; if (state_leds !== 4'b0001 || underrun !== 1'b0) begin n_bad++; $display("FAIL pause_stop got leds=%b underrun=%b want 0001 0", state_leds, underrun); end
        press(2'b01);
        n_cmp++; if (state_leds !== 4'b0010) begin n_bad++; $display("FAIL replay got %b want 0010", state_leds); end
    endtask

    task automatic test_simultaneous_rw();
        logic [15:0] exp_s;
        for (int i = 0; i < 8; i++) push(16'h00A0 + 16'(i));
        n_cmp++; if (fill_req !== 1'b1) begin n_bad++; $display("FAIL hyst_fill_req got %b want 1", fill_req); end
        fill_data  = 16'h00B0;
        fill_valid = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        fill_valid = 1'b0;
        frame_tick = 1'b0;
        n_cmp++; if (dac_load !== 1'b1 || dac_sample !== 16'h00A0) begin n_bad++; $display("FAIL rw_pop got load=%b sample=%h want 1 00a0", dac_load, dac_sample); end
        for (int i = 1; i <= 8; i++) begin
            exp_s = (i == 8) ? 16'h00B0 : 16'h00A0 + 16'(i);
            tick();
            n_cmp++;
            if (dac_load !== 1'b1 || dac_sample !== exp_s) begin
                n_bad++;
                $display("FAIL rw_drain_%0d got load=%b sample=%h want 1 %h", i, dac_load, dac_sample, exp_s);
            end
        end
        n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL rw_no_underrun got %b want 0", underrun); end
        n_cmp++; if (sample_count !== 24'd9) begin n_bad++; $display("FAIL rw_count got %0d want 9", sample_count); end
        tick();
        n_cmp++; if (underrun !== 1'b1 || dac_sample !== 16'h00B0) begin n_bad++; $display("FAIL rw_empty got underrun=%b sample=%h want 1 00b0", underrun, dac_sample); end
    endtask

    task automatic test_reset_midplay();
        logic saw_load;
        for (int i = 1; i <= 10; i++) push(16'h0030 + 16'(i));
        tick();
        n_cmp++; if (dac_sample !== 16'h0031 || sample_count !== 24'd10) begin n_bad++; $display("FAIL pre_rst got sample=%h count=%0d want 0031 10", dac_sample, sample_count); end
        rst = 1'b1;
        #1;
        n_cmp++; if (state_leds !== 4'b0001) begin n_bad++; $display("FAIL mid_rst_leds got %b want 0001", state_leds); end
        n_cmp++; if (dac_sample !== 16'h0000 || dac_load !== 1'b0) begin n_bad++; $display("FAIL mid_rst_dac got sample=%h load=%b want 0000 0", dac_sample, dac_load); end
        n_cmp++; if (fill_ready !== 1'b0 || fill_req !== 1'b0) begin n_bad++; $display("FAIL mid_rst_fill got ready=%b req=%b want 0 0", fill_ready, fill_req); end
        n_cmp++; if (underrun !== 1'b0 || sample_count !== 24'd0) begin n_bad++; $display("FAIL mid_rst_status got underrun=%b count=%0d want 0 0", underrun, sample_count); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        saw_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (dac_load !== 1'b0) saw_load = 1'b1;
        end
        n_cmp++; if (saw_load !== 1'b0) begin n_bad++; $display("FAIL post_rst_load got pulse want none"); end
        press(2'b01);
        tick();
        n_cmp++; if (underrun !== 1'b1 || dac_sample !== 16'h0000) begin n_bad++; $display("FAIL discarded got underrun=%b sample=%h want 1 0000", underrun, dac_sample); end
    endtask

    initial begin
        rst        = 1'b1;
        pb_n       = 4'hF;
        fill_data  = '0;
        fill_valid = 1'b0;
        frame_tick = 1'b0;
        test_reset();
        test_play_press();
        test_fill_drain();
        test_underrun();
        test_simul_stop();
        test_held_button();
        test_simultaneous_rw();
        test_reset_midplay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
